// File: rtl/ex_commit_if.sv
// Execute-to-commit bundle: per-unit result pulses with back-pressure, plus the
// registered register-file write / retire port.
interface ex_commit_if #(
  parameter int XLEN = 64,
  parameter int RNW  = 6
);
  logic            alu_valid;
  logic [RNW-1:0]  alu_rn;
  logic [XLEN-1:0] alu_data;
  logic            alu_stall;

  logic            adv_valid;
  logic [RNW-1:0]  adv_rn;
  logic [RNW-1:0]  adv_rn2;
  logic [XLEN-1:0] adv_data;
  logic [XLEN-1:0] adv_data2;
  logic            adv_stall;

  logic            mem_valid;
  logic [RNW-1:0]  mem_rn;
  logic [XLEN-1:0] mem_data;
  logic            mem_stall;

  logic            rf_we;
  logic [RNW-1:0]  rf_wa;
  logic [XLEN-1:0] rf_wd;

  modport master (
    output alu_valid, alu_rn, alu_data,
    output adv_valid, adv_rn, adv_rn2, adv_data, adv_data2,
    output mem_valid, mem_rn, mem_data,
    input  alu_stall, adv_stall, mem_stall,
    input  rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  alu_valid, alu_rn, alu_data,
    input  adv_valid, adv_rn, adv_rn2, adv_data, adv_data2,
    input  mem_valid, mem_rn, mem_data,
    output alu_stall, adv_stall, mem_stall,
    output rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/ex_commit.sv
// Commit stage: buffers ALU/ADV/MEM result pulses in 2-entry FIFOs and
// round-robins them onto the single register-file write port.
module ex_commit #(
  parameter int XLEN = 64,
  parameter int RNW  = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  ex_commit_if.slave bus
);
  localparam int         NSRC    = 3;
  localparam logic [1:0] SRC_ADV = 2'd1;

  typedef struct packed {
    logic [RNW-1:0]  rn;
    logic [RNW-1:0]  rn2;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] data2;
  } entry_t;

  typedef enum logic {PH_FIRST, PH_SECOND} phase_t;

  entry_t          fifo     [NSRC][2];
  logic [1:0]      count    [NSRC];
  entry_t          in_entry [NSRC];
  logic [NSRC-1:0] in_valid;
  logic [NSRC-1:0] nonempty;
  logic [NSRC-1:0] push_ok;
  logic [NSRC-1:0] pop;
  logic [NSRC-1:0] stall;
  logic [1:0]      rr;
  logic [1:0]      grant;
  logic [1:0]      cand1;
  logic [1:0]      cand2;
  logic            any_ready;
  phase_t          phase;
  entry_t          head;

  logic            rf_we_q;
  logic [RNW-1:0]  rf_wa_q;
  logic [XLEN-1:0] rf_wd_q;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    in_valid    = {bus.mem_valid, bus.adv_valid, bus.alu_valid};
    in_entry[0] = '{rn: bus.alu_rn, rn2: '0, data: bus.alu_data, data2: '0};
    in_entry[1] = '{rn: bus.adv_rn, rn2: bus.adv_rn2, data: bus.adv_data, data2: bus.adv_data2};
    in_entry[2] = '{rn: bus.mem_rn, rn2: '0, data: bus.mem_data, data2: '0};
    for (int i = 0; i < NSRC; i++) begin
      nonempty[i] = (count[i] != 2'd0);
      push_ok[i]  = in_valid[i] && (count[i] != 2'd2);
      stall[i]    = (count[i] == 2'd2) || ((count[i] == 2'd1) && in_valid[i]);
    end
  end

  // Round-robin from rr; the grant stays on ADV while its second half is due.
  always_comb begin
    cand1     = next_src(rr);
    cand2     = next_src(cand1);
    any_ready = |nonempty;
    grant     = cand2;
    if (phase == PH_SECOND)  grant = SRC_ADV;
    else if (nonempty[rr])   grant = rr;
    else if (nonempty[cand1]) grant = cand1;
    head = fifo[grant][0];
    pop  = '0;
    if (any_ready && (grant != SRC_ADV || phase == PH_SECOND)) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
      rr      <= 2'd0;
      phase   <= PH_FIRST;
      for (int i = 0; i < NSRC; i++) count[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NSRC; i++)
        count[i] <= count[i] + {1'b0, push_ok[i]} - {1'b0, pop[i]};
      if (any_ready) begin
        if (phase == PH_SECOND) begin
          rf_wa_q <= head.rn2;
          rf_wd_q <= head.data2;
          rf_we_q <= (head.rn2 != '0);
        end else begin
          rf_wa_q <= head.rn;
          rf_wd_q <= head.data;
          rf_we_q <= (head.rn != '0);
        end
        if (grant == SRC_ADV) phase <= (phase == PH_FIRST) ? PH_SECOND : PH_FIRST;
        if (pop[grant]) rr <= next_src(grant);
      end else begin
        rf_we_q <= 1'b0;
      end
    end
  end

  // NOTE: the FIFO payload is not reset; counts alone define validity, so
  // stale contents are never observed and the storage stays reset-free.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (pop[i]) begin
        if (count[i] == 2'd2)  fifo[i][0] <= fifo[i][1];
        else if (push_ok[i])   fifo[i][0] <= in_entry[i];
      end else if (push_ok[i]) begin
        if (count[i] == 2'd0)  fifo[i][0] <= in_entry[i];
        else                   fifo[i][1] <= in_entry[i];
      end
    end
  end

  assign bus.alu_stall = stall[0];
  assign bus.adv_stall = stall[1];
  assign bus.mem_stall = stall[2];
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_wa     = rf_wa_q;
  assign bus.rf_wd     = rf_wd_q;
endmodule

// File: tb/tb_ex_commit.sv
// Self-checking bench for ex_commit: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based transaction model.
module tb_ex_commit;
  localparam int XLEN = 64;
  localparam int RNW  = 6;

  logic clk;
  logic rst_n;

  ex_commit_if #(.XLEN(XLEN), .RNW(RNW)) bus();

  ex_commit #(.XLEN(XLEN), .RNW(RNW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RNW-1:0]  rn;
    logic [RNW-1:0]  rn2;
    logic [XLEN-1:0] d;
    logic [XLEN-1:0] d2;
  } ent_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: pending results per source, in arrival order.
  ent_t q0[$];
  ent_t q1[$];
  ent_t q2[$];
  bit              half;
  int              rr_m;
  logic            m_we;
  logic [RNW-1:0]  m_wa;
  logic [XLEN-1:0] m_wd;

  logic            obs_we;
  logic [RNW-1:0]  obs_wa;
  logic [XLEN-1:0] obs_wd;
  logic [2:0]      obs_stall;

  logic            lw [16];
  logic [RNW-1:0]  la [16];
  logic [XLEN-1:0] ld [16];
  logic [2:0]      ls [16];

  function automatic int qsize(input int s);
    case (s)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ent_t qfront(input int s);
    case (s)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpop(input int s);
    case (s)
      0:       q0.delete(0);
      1:       q1.delete(0);
      default: q2.delete(0);
    endcase
  endfunction

  function automatic void model_clear();
    q0.delete(); q1.delete(); q2.delete();
    half = 0; rr_m = 0; m_we = 1'b0; m_wa = '0; m_wd = '0;
  endfunction

  function automatic logic valid_of(input int s);
    case (s)
      0:       return bus.alu_valid;
      1:       return bus.adv_valid;
      default: return bus.mem_valid;
    endcase
  endfunction

  // One clock edge of the model: retire one write slot, then accept arrivals.
  function automatic void model_edge();
    int   src;
    bit   found;
    ent_t e;
    found = 0;
    src   = 0;
    if (half) begin
      src = 1; found = 1;
    end else begin
      for (int k = 0; k < 3; k++)
        if (!found && qsize((rr_m + k) % 3) > 0) begin
          src = (rr_m + k) % 3; found = 1;
        end
    end
    if (found) begin
      e = qfront(src);
      if (src == 1 && !half) begin
        m_we = (e.rn != 0); m_wa = e.rn; m_wd = e.d; half = 1;
      end else if (src == 1) begin
        m_we = (e.rn2 != 0); m_wa = e.rn2; m_wd = e.d2; half = 0;
        qpop(1); rr_m = 2;
      end else begin
        m_we = (e.rn != 0); m_wa = e.rn; m_wd = e.d;
        qpop(src); rr_m = (src + 1) % 3;
      end
    end else begin
      m_we = 1'b0;
    end
    if (bus.alu_valid) q0.push_back('{rn: bus.alu_rn, rn2: '0, d: bus.alu_data, d2: '0});
    if (bus.adv_valid) q1.push_back('{rn: bus.adv_rn, rn2: bus.adv_rn2, d: bus.adv_data, d2: bus.adv_data2});
    if (bus.mem_valid) q2.push_back('{rn: bus.mem_rn, rn2: '0, d: bus.mem_data, d2: '0});
  endfunction

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rn = '0; bus.alu_data = '0;
    bus.adv_valid = 1'b0; bus.adv_rn = '0; bus.adv_rn2 = '0;
    bus.adv_data  = '0;   bus.adv_data2 = '0;
    bus.mem_valid = 1'b0; bus.mem_rn = '0; bus.mem_data = '0;
  endtask

  task automatic set_alu(input logic [RNW-1:0] rn, input logic [XLEN-1:0] d);
    bus.alu_valid = 1'b1; bus.alu_rn = rn; bus.alu_data = d;
  endtask

  task automatic set_adv(input logic [RNW-1:0] rn, input logic [XLEN-1:0] d,
                         input logic [RNW-1:0] rn2, input logic [XLEN-1:0] d2);
    bus.adv_valid = 1'b1; bus.adv_rn = rn; bus.adv_data = d;
    bus.adv_rn2 = rn2; bus.adv_data2 = d2;
  endtask

  task automatic set_mem(input logic [RNW-1:0] rn, input logic [XLEN-1:0] d);
    bus.mem_valid = 1'b1; bus.mem_rn = rn; bus.mem_data = d;
  endtask

  // Called at a negedge with this cycle's inputs driven: compare outputs to
  // the model, then advance DUT and model across the next rising edge.
  task automatic tick();
    logic es;
    #1;
    obs_we    = bus.rf_we;
    obs_wa    = bus.rf_wa;
    obs_wd    = bus.rf_wd;
    obs_stall = {bus.mem_stall, bus.adv_stall, bus.alu_stall};
    total++;
    if (obs_we !== m_we) begin
      bad++; $display("FAIL rf_we cyc=%0d got=%b exp=%b", cyc, obs_we, m_we);
    end
    total++;
    if (obs_wa !== m_wa || obs_wd !== m_wd) begin
      bad++; $display("FAIL rf_wa/wd cyc=%0d got=%0d/%h exp=%0d/%h", cyc, obs_wa, obs_wd, m_wa, m_wd);
    end
    for (int s = 0; s < 3; s++) begin
      es = (qsize(s) == 2) || (qsize(s) == 1 && valid_of(s));
      total++;
      if (obs_stall[s] !== es) begin
        bad++; $display("FAIL stall[%0d] cyc=%0d got=%b exp=%b", s, cyc, obs_stall[s], es);
      end
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic log_tick(input int c);
    tick();
    lw[c] = obs_we; la[c] = obs_wa; ld[c] = obs_wd; ls[c] = obs_stall;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++;
    if (bus.rf_we !== 1'b0 || bus.rf_wa !== '0 || bus.rf_wd !== '0) begin
      bad++; $display("FAIL reset_rf got we=%b wa=%0d wd=%h exp 0/0/0", bus.rf_we, bus.rf_wa, bus.rf_wd);
    end
    total++;
    if ({bus.mem_stall, bus.adv_stall, bus.alu_stall} !== 3'b000) begin
      bad++; $display("FAIL reset_stall got=%b exp=000", {bus.mem_stall, bus.adv_stall, bus.alu_stall});
    end
    @(negedge clk);
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_single_alu();
    logic exp_we [5] = '{0, 0, 1, 0, 0};
    for (int c = 0; c < 5; c++) begin
      if (c == 0) set_alu(6'd5, 64'h1234); else idle();
      log_tick(c);
    end
    for (int c = 0; c < 5; c++) begin
      total++;
      if (lw[c] !== exp_we[c] || ls[c][0] !== 1'b0) begin
        bad++; $display("FAIL single_alu c%0d got we=%b stall=%b exp we=%b stall=0", c, lw[c], ls[c][0], exp_we[c]);
      end
    end
    total++;
    if (la[2] !== 6'd5 || ld[2] !== 64'h1234) begin
      bad++; $display("FAIL single_alu_data got %0d/%h exp 5/1234", la[2], ld[2]);
    end
  endtask

  task automatic test_adv_pair();
    logic exp_we [6] = '{0, 0, 1, 1, 0, 0};
    for (int c = 0; c < 6; c++) begin
      if (c == 0) set_adv(6'd3, 64'hAAAA, 6'd4, 64'hBBBB); else idle();
      log_tick(c);
    end
    for (int c = 0; c < 6; c++) begin
      total++;
      if (lw[c] !== exp_we[c]) begin
        bad++; $display("FAIL adv_pair c%0d got we=%b exp=%b", c, lw[c], exp_we[c]);
      end
    end
    total++;
    if (la[2] !== 6'd3 || ld[2] !== 64'hAAAA || la[3] !== 6'd4 || ld[3] !== 64'hBBBB) begin
      bad++; $display("FAIL adv_pair_data got %0d/%h %0d/%h exp 3/aaaa 4/bbbb", la[2], ld[2], la[3], ld[3]);
    end
  endtask

  task automatic test_discard();
    logic exp_we [7] = '{0, 0, 0, 0, 1, 0, 0};
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c == 0) set_alu(6'd0, 64'h55);
      if (c == 1) set_adv(6'd0, 64'h66, 6'd7, 64'h77);
      log_tick(c);
    end
    for (int c = 0; c < 7; c++) begin
      total++;
      if (lw[c] !== exp_we[c]) begin
        bad++; $display("FAIL discard c%0d got we=%b exp=%b", c, lw[c], exp_we[c]);
      end
    end
    total++;
    if (la[4] !== 6'd7 || ld[4] !== 64'h77) begin
      bad++; $display("FAIL discard_r7 got %0d/%h exp 7/77", la[4], ld[4]);
    end
  endtask

  task automatic test_contention();
    logic [RNW-1:0] exp_wa [4] = '{1, 2, 3, 4};
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c == 0) begin
        set_alu(6'd1, 64'h11); set_adv(6'd2, 64'h22, 6'd3, 64'h33); set_mem(6'd4, 64'h44);
      end
      log_tick(c);
    end
    for (int c = 2; c < 6; c++) begin
      total++;
      if (lw[c] !== 1'b1 || la[c] !== exp_wa[c-2]) begin
        bad++; $display("FAIL contention c%0d got we=%b wa=%0d exp we=1 wa=%0d", c, lw[c], la[c], exp_wa[c-2]);
      end
    end
    total++;
    if (lw[6] !== 1'b0) begin
      bad++; $display("FAIL contention_idle got we=%b exp=0", lw[6]);
    end
    // Pointer back at ALU: a simultaneous ALU/MEM pair must write ALU first.
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 0) begin set_alu(6'd30, 64'h30); set_mem(6'd31, 64'h31); end
      log_tick(c);
    end
    total++;
    if (la[2] !== 6'd30 || la[3] !== 6'd31) begin
      bad++; $display("FAIL contention_rr got %0d,%0d exp 30,31", la[2], la[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [RNW-1:0] exp_wa [6] = '{10, 12, 13, 11, 14, 15};
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c == 0) begin
        set_alu(6'd10, 64'hA0); set_mem(6'd11, 64'hB0); set_adv(6'd12, 64'hC0, 6'd13, 64'hD0);
      end
      if (c == 1) set_adv(6'd14, 64'hE0, 6'd15, 64'hF0);
      log_tick(c);
    end
    total++;
    if (ls[0][1] !== 1'b0 || ls[1][1] !== 1'b1 || ls[2][1] !== 1'b1 || ls[4][1] !== 1'b0) begin
      bad++; $display("FAIL backpressure adv_stall c0..c4 got %b%b%b%b exp 0110", ls[0][1], ls[1][1], ls[2][1], ls[4][1]);
    end
    for (int c = 2; c < 8; c++) begin
      total++;
      if (lw[c] !== 1'b1 || la[c] !== exp_wa[c-2]) begin
        bad++; $display("FAIL back_to_back c%0d got we=%b wa=%0d exp we=1 wa=%0d", c, lw[c], la[c], exp_wa[c-2]);
      end
    end
    total++;
    if (lw[8] !== 1'b0) begin
      bad++; $display("FAIL back_to_back_idle got we=%b exp=0", lw[8]);
    end
  endtask

  task automatic test_reset_mid_pair();
    apply_reset();
    set_adv(6'd20, 64'h20, 6'd21, 64'h21);
    tick();
    idle();
    tick();
    #1;
    total++;
    if (bus.rf_we !== 1'b1 || bus.rf_wa !== 6'd20) begin
      bad++; $display("FAIL midpair_first got we=%b wa=%0d exp we=1 wa=20", bus.rf_we, bus.rf_wa);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.rf_we !== 1'b0 || bus.rf_wa !== '0 || bus.rf_wd !== '0) begin
      bad++; $display("FAIL midpair_reset got we=%b wa=%0d wd=%h exp 0/0/0", bus.rf_we, bus.rf_wa, bus.rf_wd);
    end
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      log_tick(c);
      total++;
      if (lw[c] !== 1'b0) begin
        bad++; $display("FAIL midpair_residual c%0d got we=%b exp=0", c, lw[c]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) set_alu(6'd9, 64'h99);
      log_tick(c);
    end
    total++;
    if (lw[2] !== 1'b1 || la[2] !== 6'd9 || lw[3] !== 1'b0) begin
      bad++; $display("FAIL midpair_after got we=%b wa=%0d next we=%b exp 1/9/0", lw[2], la[2], lw[3]);
    end
  endtask

  function automatic logic [RNW-1:0] rand_rn();
    return ($urandom_range(0, 7) == 0) ? '0 : RNW'($urandom_range(1, 63));
  endfunction

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      if (qsize(0) < 2 && $urandom_range(0, 1) == 1) set_alu(rand_rn(), {$urandom(), $urandom()});
      if (qsize(1) < 2 && $urandom_range(0, 2) == 0)
        set_adv(rand_rn(), {$urandom(), $urandom()}, rand_rn(), {$urandom(), $urandom()});
      if (qsize(2) < 2 && $urandom_range(0, 1) == 1) set_mem(rand_rn(), {$urandom(), $urandom()});
      tick();
    end
    idle();
    for (int n = 0; n < 12; n++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_clear();
    @(negedge clk);
    test_reset();
    test_single_alu();
    test_adv_pair();
    test_discard();
    test_contention();
    test_back_to_back();
    test_reset_mid_pair();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog cycle budget exhausted");
    $fatal(1);
  end
endmodule

// File: doc/ex_commit.md
# ex_commit

Commit stage directly downstream of the execute units: the simple integer ALU, the advanced integer unit and the memory unit. It captures each unit's one-cycle result pulse into a per-unit 2-entry buffer and back-pressures the unit through its `stall` input. It round-robin arbitrates the buffered results onto the single register-file write port; dual-result advanced-integer operations (e.g. product high/low, quotient/remainder) are written over two consecutive cycles. The registered write port also serves as the retire/scoreboard-clear signal for dispatch.

## Interface
- XLEN, 64, result data width
- RNW, 6, register-number width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle (single-cycle pulse)
- alu_rn  in  RNW  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_stall  out  1  back-pressure to ALU
- adv_valid  in  1  advanced-integer result pair present this cycle
- adv_rn, adv_rn2  in  RNW  first/second destination registers
- adv_data, adv_data2  in  XLEN  first/second results
- adv_stall  out  1  back-pressure to advanced-integer unit
- mem_valid  in  1  memory-unit load result present this cycle
- mem_rn  in  RNW  load destination register
- mem_data  in  XLEN  load data
- mem_stall  out  1  back-pressure to memory unit
- rf_we  out  1  register-file write enable (registered)
- rf_wa  out  RNW  write address (registered)
- rf_wd  out  XLEN  write data (registered)

## Operation
- Source indices: ALU=0, ADV=1, MEM=2. Each source has a 2-entry FIFO with a 2-bit count (0..2).
- A valid pulse is pushed unconditionally on the clock edge ending the valid cycle. Upstream results last one cycle only and are never retransmitted.
- stall_x = (count_x==2) | (count_x==1 & x_valid). The stall is combinational from registered count and the incoming valid. This guarantees that a result can never arrive while the FIFO is full.
- Arbiter: a round-robin pointer rr (0..2). The first non-empty FIFO starting at rr is granted. rr moves to grant+1 (mod 3) when the granted entry retires.
- ALU/MEM entry: one write cycle. rf_wa=rn, rf_wd=data, rf_we=(rn!=0). The entry pops on the same edge.
- ADV entry: two write cycles, tracked by a phase bit.
  - Phase 0 writes rn/data with we=(rn!=0); no pop.
  - Phase 1 writes rn2/data2 with we=(rn2!=0); the entry pops and rr advances.
  - The grant is locked to ADV between the phases.
- Register 0 is a discard destination. Writes to it are suppressed, but the cycle is still consumed.
- Push and pop on the same FIFO in the same edge: count unchanged, data order preserved.
- When no FIFO is non-empty, rf_we=0 and rf_wa/rf_wd hold their last values.

## Timing
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, all counts=0, rr=0, phase=0. With counts at 0 and upstream valids reset low, all stalls are 0.
- Reset asserted mid-operation discards all buffered results and any half-written ADV pair. No write occurs after reset deasserts until a new valid arrives.
- Latency: a valid in cycle t is pushed at end of t, arbitrated in t+1, and appears as rf_we in t+2 (minimum, uncontended).
- Throughput: one register write per cycle. Sustained ALU/MEM issue is one per 2 cycles per source, due to the stall rule.
- Worst-case wait for an entry at a FIFO head is 3 write cycles (the other sources' heads, with ADV counted as 2) before its own grant.
- The stall rises in the same cycle as valid when count==1. Upstream must not issue in a cycle where its stall is 1.

## Test plan
- Single ALU: alu_valid=1, rn=5, data=0x1234 in cycle 0 -> rf_we=1, wa=5, wd=0x1234 in cycle 2 only; alu_stall stays 0.
- ADV pair: rn=3/0xAAAA, rn2=4/0xBBBB in cycle 0 -> cycle 2 writes r3=0xAAAA, cycle 3 writes r4=0xBBBB; no other writes.
- Discard: ALU rn=0; then ADV rn=0, rn2=7/0x77 -> ALU consumes 1 cycle and ADV 2, with rf_we=0 in all but the r7 write.
- Contention: ALU r1, ADV r2/r3, MEM r4 valid in the same cycle, rr=0 -> writes r1, r2, r3, r4 in cycles 2..5; rr ends at 0.
- Back-pressure: ADV valid in cycles 0 and 1 while ALU and MEM are busy -> adv_stall=1 in cycle 1 (count 1 and valid). No overflow, both pairs are written in order, and adv_stall=0 once count<=1 with no valid.
- Reset mid-pair: rst_n low during phase 1 of an ADV write -> rf_we=0 immediately, counts 0, no residual writes after release.
